// File: rtl/rr_mux2_arbiter.sv
// rr_mux2_arbiter: round-robin owner of a shared 2:1 mux datapath with burst-limited multi-beat grants
module rr_mux2_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic             last0,
    input  logic             last1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);
    localparam int CW = $clog2(MAX_BURST + 2);
    localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);

    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             own, own1, req_x, req_y, last_x, beat, rel;
    logic [WIDTH-1:0] data_x;
    logic [CW-1:0]    cnt_inc;

    // owner-relative view of the requesters, release decision and next state
    always_comb begin
        own         = state_q != IDLE;
        own1        = state_q == OWN1;
        req_x       = own1 ? req1 : req0;
        req_y       = own1 ? req0 : req1;
        last_x      = own1 ? last1 : last0;
        data_x      = own1 ? data1 : data0;
        cnt_inc     = cnt_q + CW'(1);
        beat        = own && req_x;
        rel         = own && (!req_x || last_x || (cnt_inc >= MAXC && req_y));
        state_d     = own ? (rel ? (req_y ? (own1 ? OWN0 : OWN1) : IDLE) : state_q)
                          : ((req0 && req1) ? (ptr_q ? OWN1 : OWN0)
                          : req0 ? OWN0 : req1 ? OWN1 : IDLE);
        ptr_d       = rel ? !own1 : ptr_q;
        cnt_d       = rel ? '0 : beat ? (cnt_q >= MAXC ? cnt_q : cnt_inc) : cnt_q;
        out_valid_d = beat;
        out_data_d  = beat ? data_x : out_data_q;
    end

    // state, pointer, burst count and output beat registers; reset aborts any transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign gnt0      = state_q == OWN0;
    assign gnt1      = state_q == OWN1;
    assign sel       = state_q == OWN1;
    assign busy      = state_q != IDLE;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
endmodule

// File: tb/tb_rr_mux2_arbiter.sv
// tb_rr_mux2_arbiter: directed scoreboard bench for the round-robin mux arbiter
module tb_rr_mux2_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0, last0 = 1'b0, last1 = 1'b0;
    logic [7:0] data0 = '0, data1 = '0;
    logic       gnt0, gnt1, sel, out_valid, busy;
    logic [7:0] out_data;
    logic [7:0] exp_q[$];
    int         checks = 0;
    int         failures = 0;

    rr_mux2_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .data0(data0), .data1(data1), .last0(last0), .last1(last1),
        .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .out_valid(out_valid),
        .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // monitor: every presented beat must match the oldest expected beat
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat got=%0h exp=none at %0t", out_data, $time);
            end else begin
                chk("beat_data", {24'b0, out_data}, {24'b0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        // reset with toggling inputs
        for (int i = 0; i < 2; i++) begin
            req0 = 1'($urandom); req1 = 1'($urandom);
            last0 = 1'($urandom); last1 = 1'($urandom);
            data0 = 8'($urandom); data1 = 8'($urandom);
            step();
        end
        chk("rst_gnt0", gnt0, 0); chk("rst_gnt1", gnt1, 0); chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0); chk("rst_valid", out_valid, 0); chk("rst_data", out_data, 0);
        rst = 0; req0 = 0; req1 = 0; last0 = 0; last1 = 0; data0 = 0; data1 = 0;
        step();
        // single 3-beat packet from requester 0
        req0 = 1; data0 = 8'h11;
        step();
        chk("t2_gnt0", gnt0, 1); chk("t2_valid0", out_valid, 0);
        exp_q.push_back(8'h11); step();
        chk("t2_valid1", out_valid, 1);
        data0 = 8'h22; exp_q.push_back(8'h22); step();
        data0 = 8'h33; last0 = 1; exp_q.push_back(8'h33); step();
        chk("t2_idle", busy, 0);
        req0 = 0; last0 = 0; req1 = 0;
        step();
        // ptr now 1: a tie goes to requester 1; dropping both releases without a beat
        req0 = 1; req1 = 1;
        step();
        chk("t2_ptr_gnt1", gnt1, 1); chk("t2_ptr_gnt0", gnt0, 0);
        req0 = 0; req1 = 0;
        step();
        chk("t2_drop_idle", busy, 0); chk("t2_drop_novalid", out_valid, 0);
        // fresh reset, then simultaneous 2-beat packets
        rst = 1; step(); rst = 0;
        req0 = 1; req1 = 1; data0 = 8'hA0; data1 = 8'hB0;
        step();
        chk("t3_gnt0", gnt0, 1); chk("t3_sel0", sel, 0);
        exp_q.push_back(8'hA0); step();
        chk("t3_v0", out_valid, 1);
        data0 = 8'hA1; last0 = 1; exp_q.push_back(8'hA1); step();
        chk("t3_v1", out_valid, 1); chk("t3_gnt1", gnt1, 1); chk("t3_sel1", sel, 1);
        req0 = 0; last0 = 0; data0 = 8'hEE;
        exp_q.push_back(8'hB0); step();
        chk("t3_v2", out_valid, 1);
        data1 = 8'hB1; last1 = 1; exp_q.push_back(8'hB1); step();
        chk("t3_v3", out_valid, 1); chk("t3_end_idle", busy, 0);
        req1 = 0; last1 = 0;
        step();
        // contention: burst limit of 4, then hand back after requester 1's last
        req0 = 1; req1 = 1;
        step();
        chk("t4_gnt0", gnt0, 1);
        for (int i = 0; i < 4; i++) begin
            data0 = 8'h40 + 8'(i); exp_q.push_back(data0); step();
            chk(i == 3 ? "t4_gnt1_after_limit" : "t4_gnt0_hold", i == 3 ? gnt1 : gnt0, 1);
        end
        chk("t4_sel", sel, 1);
        data1 = 8'h50; exp_q.push_back(8'h50); step();
        data1 = 8'h51; last1 = 1; exp_q.push_back(8'h51); step();
        chk("t4_back_gnt0", gnt0, 1); chk("t4_back_sel", sel, 0);
        req1 = 0; last1 = 0;
        // uncontended streaming: 10 beats, grant held throughout
        for (int i = 0; i < 10; i++) begin
            data0 = 8'h60 + 8'(i); exp_q.push_back(data0); step();
            chk("t5_gnt0_hold", gnt0, 1);
        end
        req0 = 0;
        step();
        chk("t5_idle", busy, 0); chk("t5_novalid", out_valid, 0);
        // reset during second beat of an OWN1 transfer
        req1 = 1; data1 = 8'hC0;
        step();
        chk("t6_gnt1", gnt1, 1);
        exp_q.push_back(8'hC0); step();
        data1 = 8'hC1; rst = 1; step();
        chk("t6_rst_gnt1", gnt1, 0); chk("t6_rst_valid", out_valid, 0); chk("t6_rst_data", out_data, 0);
        rst = 0; req0 = 1; req1 = 1;
        step();
        chk("t6_ptr0_gnt0", gnt0, 1);
        req0 = 0; req1 = 0;
        step();
        // drop req1 mid-burst
        req1 = 1; data1 = 8'hD0;
        step();
        exp_q.push_back(8'hD0); step();
        req1 = 0; data1 = 8'hD1;
        step();
        chk("t6_drop_idle", busy, 0); chk("t6_drop_novalid", out_valid, 0);
        step(); step();
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
